uart_rx_param: RTL and testbench

Parametrised UART receiver, successor to the fixed 8N1 receiver.
- Configurable baud divider, oversampling rate, data width, parity mode and stop-bit count.
- 3-sample majority vote on every bit.
- Reports framing error, parity error and break per received word.
- Buffers received words in a small FWFT FIFO with valid/ready output handshake and overrun reporting.
- Sits between the async pad input and the register/bus interface.

---
 rtl/uart_rx_param.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority vote, framing, parity and
// break detection. Received words are queued in a small first-word-fall-through
// FIFO with a valid/ready handshake on the consumer side.
module uart_rx_param #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_brk,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int M       = OVERSAMPLE / 2;
    localparam int BW      = $clog2(DATA_BITS);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;
    localparam int EW      = DATA_BITS + 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2,
        S_WAIT_HIGH
    } state_t;

    // Synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_rxs;

    // Receive FSM
    state_t                r_state;
    logic [TW-1:0]         r_tick_cnt;
    logic [SW-1:0]         r_s;
    logic [BW-1:0]         r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_bit;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_v0;
    logic                  r_v1;

    logic                  w_tick;
    logic                  w_vote_now;
    logic                  w_bit_end;
    logic                  w_vote;
    logic                  w_last_stop;
    logic                  w_push;
    logic                  w_push_ferr;
    logic                  w_push_brk;
    logic                  w_parity_exp;
    logic [EW-1:0]         w_entry;

    // FIFO
    logic [EW-1:0]         r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overrun;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_drop;
    logic [EW-1:0]         w_head;

    // Two-flop synchroniser; the line idles high so both stages reset to 1.
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_line;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxs = r_sync2;

    assign w_tick       = (r_state != S_IDLE) && (r_tick_cnt == TW'(DIV - 1));
    assign w_vote_now   = w_tick && (r_s == SW'(M + 1));
    assign w_bit_end    = w_tick && (r_s == SW'(OVERSAMPLE - 1));
    assign w_vote       = (r_v0 & r_v1) | (r_v0 & w_rxs) | (r_v1 & w_rxs);
    assign w_last_stop  = (STOP_BITS == 2) ? (r_state == S_STOP2) : (r_state == S_STOP1);
    assign w_push       = w_vote_now && w_last_stop;
    // r_ferr only carries the first stop bit's result in two-stop-bit frames;
    // it is cleared on every start, so it is a no-op for one stop bit.
    assign w_push_ferr  = r_ferr | ~w_vote;
    assign w_push_brk   = w_push_ferr && (r_shift == '0) &&
                          ((PARITY == 0) ? 1'b1 : ~r_par_bit);
    assign w_parity_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);
    assign w_entry      = {w_push_brk, w_push_ferr, r_perr, r_shift};

    // Oversampling tick divider, parked at zero while idle so a start edge
    // always begins a fresh bit period.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Frame FSM: walks start/data/parity/stop bits and votes on each one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_s       <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_v0      <= 1'b1;
            r_v1      <= 1'b1;
        end else begin
            if (w_tick && r_s == SW'(M - 1)) r_v0 <= w_rxs;
            if (w_tick && r_s == SW'(M))     r_v1 <= w_rxs;

            if (w_tick) begin
                r_s <= (r_s == SW'(OVERSAMPLE - 1)) ? '0 : r_s + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (!w_rxs) begin
                        r_state   <= S_START;
                        r_s       <= '0;
                        r_bit_idx <= '0;
                        r_par_bit <= 1'b0;
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_vote_now && w_vote) begin
                        // Start bit did not hold low through its centre: a glitch.
                        r_state <= S_IDLE;
                        r_s     <= '0;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_vote_now) r_shift[r_bit_idx] <= w_vote;
                    if (w_bit_end) begin
                        if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                            r_bit_idx <= '0;
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_vote_now) begin
                        r_par_bit <= w_vote;
                        r_perr    <= w_vote ^ w_parity_exp;
                    end
                    if (w_bit_end) r_state <= S_STOP1;
                end
                S_STOP1: begin
                    if (w_vote_now) begin
                        if (STOP_BITS == 1) begin
                            r_state <= w_push_ferr ? S_WAIT_HIGH : S_IDLE;
                            r_s     <= '0;
                        end else begin
                            r_ferr <= ~w_vote;
                        end
                    end else if (w_bit_end && STOP_BITS == 2) begin
                        r_state <= S_STOP2;
                    end
                end
                S_STOP2: begin
                    if (w_vote_now) begin
                        r_state <= w_push_ferr ? S_WAIT_HIGH : S_IDLE;
                        r_s     <= '0;
                    end
                end
                S_WAIT_HIGH: begin
                    // Hold off new starts until the line returns high after a break.
                    if (w_rxs) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & rx_ready;
    // A full FIFO still takes a word when the head leaves on the same edge.
    assign w_wr    = w_push & (~w_full | w_pop);
    assign w_drop  = w_push & w_full & ~w_pop;

    // FIFO storage array.
    // NOTE: the storage array has no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_entry;
    end

    // FIFO pointers, occupancy and the overrun pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_drop;
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head is forced to zero while empty so stale storage never leaks out.
    assign w_head   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rx_valid = ~w_empty;
    assign overrun  = r_overrun;
    assign {rx_brk, rx_ferr, rx_perr, rx_data} = w_head;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 instance and a 7E2 instance,
// both at 16 clocks per bit, with a scoreboard of expected FIFO words.
`timescale 1ns/1ps
module tb_uart_rx_param;

    localparam int CLK_HZ = 1600000;
    localparam int BAUD   = 100000;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       rx_a, rx_ready_a;
    logic [7:0] rx_data_a;
    logic       rx_perr_a, rx_ferr_a, rx_brk_a, rx_valid_a, overrun_a, busy_a;

    logic       rx_b, rx_ready_b;
    logic [6:0] rx_data_b;
    logic       rx_perr_b, rx_ferr_b, rx_brk_b, rx_valid_b, overrun_b, busy_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rx_line(rx_a),
        .rx_data(rx_data_a), .rx_perr(rx_perr_a), .rx_ferr(rx_ferr_a), .rx_brk(rx_brk_a),
        .rx_valid(rx_valid_a), .rx_ready(rx_ready_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_param #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rx_line(rx_b),
        .rx_data(rx_data_b), .rx_perr(rx_perr_b), .rx_ferr(rx_ferr_b), .rx_brk(rx_brk_b),
        .rx_valid(rx_valid_b), .rx_ready(rx_ready_b), .overrun(overrun_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic brk, input logic ferr, input logic perr,
                                input logic [7:0] data);
        exp_t e;
        e.brk  = brk;
        e.ferr = ferr;
        e.perr = perr;
        e.data = data;
        return e;
    endfunction

    // 8N1 frame; spike_bit inverts one clock around sample M of that bit.
    // Leaves the line at the stop-bit level.
    task automatic send_a(input logic [7:0] d, input logic stop_v, input int spike_bit);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 16; c++) begin
                rx_a = bits[j] ^ ((j == spike_bit) && (c == 9));
                @(negedge clk);
            end
        end
    endtask

    // 7E2 frame with explicit parity and stop levels; leaves line at stop2 level.
    task automatic send_b(input logic [6:0] d, input logic par, input logic s1, input logic s2);
        logic [10:0] bits;
        bits = {s2, s1, par, d, 1'b0};
        for (int j = 0; j < 11; j++) begin
            for (int c = 0; c < 16; c++) begin
                rx_b = bits[j];
                @(negedge clk);
            end
        end
    endtask

    task automatic consume_a(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!rx_valid_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rx_valid_a), 32'd1);
        check({tag, "_sb"}, 32'(q_a.size() > 0), 32'd1);
        if (rx_valid_a && q_a.size() > 0) begin
            e = q_a.pop_front();
            check({tag, "_data"}, 32'(rx_data_a), 32'(e.data));
            check({tag, "_perr"}, 32'(rx_perr_a), 32'(e.perr));
            check({tag, "_ferr"}, 32'(rx_ferr_a), 32'(e.ferr));
            check({tag, "_brk"},  32'(rx_brk_a),  32'(e.brk));
            rx_ready_a = 1'b1;
            @(negedge clk);
            rx_ready_a = 1'b0;
        end
    endtask

    task automatic consume_b(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (!rx_valid_b && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rx_valid_b), 32'd1);
        check({tag, "_sb"}, 32'(q_b.size() > 0), 32'd1);
        if (rx_valid_b && q_b.size() > 0) begin
            e = q_b.pop_front();
            check({tag, "_data"}, 32'(rx_data_b), 32'(e.data));
            check({tag, "_perr"}, 32'(rx_perr_b), 32'(e.perr));
            check({tag, "_ferr"}, 32'(rx_ferr_b), 32'(e.ferr));
            check({tag, "_brk"},  32'(rx_brk_b),  32'(e.brk));
            rx_ready_b = 1'b1;
            @(negedge clk);
            rx_ready_b = 1'b0;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic saw_valid;
        logic saw_busy;

        rst_n      = 1'b0;
        rx_a       = 1'b1;
        rx_b       = 1'b1;
        rx_ready_a = 1'b0;
        rx_ready_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data",    32'(rx_data_a),  32'd0);
        check("rst_valid",   32'(rx_valid_a), 32'd0);
        check("rst_flags",   32'({rx_perr_a, rx_ferr_a, rx_brk_a}), 32'd0);
        check("rst_busy",    32'(busy_a),     32'd0);
        check("rst_overrun", 32'(overrun_a),  32'd0);
        check("rst_valid_b", 32'(rx_valid_b), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: 8N1 0xA5, valid exactly one clock after the stop vote
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA5));
        fork
            send_a(8'hA5, 1'b1, -1);
            begin
                repeat (80) @(negedge clk);
                check("t1_busy_mid", 32'(busy_a), 32'd1);
                repeat (76) @(negedge clk);
                check("t1_valid_pre", 32'(rx_valid_a), 32'd0);
                @(negedge clk);
                check("t1_valid_lat", 32'(rx_valid_a), 32'd1);
                check("t1_busy_end",  32'(busy_a),     32'd0);
            end
        join
        consume_a("t1");
        check("t1_empty", 32'(rx_valid_a), 32'd0);

        // 2: 7E2 parity good / bad, then a second-stop-bit framing error
        q_b.push_back(mk(1'b0, 1'b0, 1'b0, 8'h55));
        send_b(7'h55, 1'b0, 1'b1, 1'b1);
        consume_b("t2_par_ok");
        q_b.push_back(mk(1'b0, 1'b0, 1'b1, 8'h55));
        send_b(7'h55, 1'b1, 1'b1, 1'b1);
        consume_b("t2_par_bad");
        q_b.push_back(mk(1'b0, 1'b1, 1'b0, 8'h2A));
        send_b(7'h2A, 1'b1, 1'b1, 1'b0);
        rx_b = 1'b1;
        consume_b("t2_stop2_err");
        repeat (4) @(negedge clk);
        check("t2_busy_b", 32'(busy_b), 32'd0);

        // 3: framing error holds WAIT_HIGH; then a 40-bit break
        q_a.push_back(mk(1'b0, 1'b1, 1'b0, 8'h3C));
        send_a(8'h3C, 1'b0, -1);
        repeat (40) @(negedge clk);
        check("t3_wait_high", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        repeat (4) @(negedge clk);
        check("t3_idle", 32'(busy_a), 32'd0);
        consume_a("t3_ferr");
        q_a.push_back(mk(1'b1, 1'b1, 1'b0, 8'h00));
        rx_a = 1'b0;
        repeat (640) @(negedge clk);
        check("t3_brk_busy", 32'(busy_a), 32'd1);
        rx_a = 1'b1;
        repeat (20) @(negedge clk);
        consume_a("t3_brk");
        check("t3_single", 32'(rx_valid_a), 32'd0);

        // 4a: 5-clock low glitch is rejected
        saw_valid = 1'b0;
        saw_busy  = 1'b0;
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        for (int i = 0; i < 200; i++) begin
            saw_valid |= rx_valid_a;
            saw_busy  |= busy_a;
            @(negedge clk);
        end
        check("t4_glitch_start", 32'(saw_busy),  32'd1);
        check("t4_glitch_nopush", 32'(saw_valid), 32'd0);
        check("t4_glitch_idle",  32'(busy_a),    32'd0);

        // 4b: single-clock spike at the centre sample is outvoted
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA5));
        send_a(8'hA5, 1'b1, 4);
        consume_a("t4_spike0");
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'hA5));
        send_a(8'hA5, 1'b1, 1);
        consume_a("t4_spike1");

        // 5: overrun on the fifth frame with rx_ready low
        for (int v = 1; v <= 4; v++) begin
            q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'(v)));
            send_a(8'(v), 1'b1, -1);
        end
        fork
            send_a(8'h05, 1'b1, -1);
            begin
                repeat (156) @(negedge clk);
                check("t5_ovr_pre",   32'(overrun_a), 32'd0);
                @(negedge clk);
                check("t5_ovr_pulse", 32'(overrun_a), 32'd1);
                @(negedge clk);
                check("t5_ovr_post",  32'(overrun_a), 32'd0);
            end
        join
        for (int i = 0; i < 4; i++) consume_a("t5_drain");
        check("t5_empty", 32'(rx_valid_a), 32'd0);

        // 5b: pop on the same edge as a push into a full FIFO
        for (int v = 8'h11; v <= 8'h15; v++) q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'(v)));
        for (int v = 8'h11; v <= 8'h14; v++) send_a(8'(v), 1'b1, -1);
        fork
            send_a(8'h15, 1'b1, -1);
            begin
                repeat (156) @(negedge clk);
                e = q_a.pop_front();
                check("t5b_head", 32'(rx_data_a), 32'(e.data));
                rx_ready_a = 1'b1;
                @(negedge clk);
                rx_ready_a = 1'b0;
                check("t5b_no_ovr", 32'(overrun_a), 32'd0);
            end
        join
        for (int i = 0; i < 4; i++) consume_a("t5b_drain");
        check("t5b_empty", 32'(rx_valid_a), 32'd0);

        // 6: reset mid-DATA with a word already queued
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'h99));
        send_a(8'h99, 1'b1, -1);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        rx_a = 1'b1;
        repeat (32) @(negedge clk);
        rx_a = 1'b0;
        repeat (16) @(negedge clk);
        check("t6_busy_pre", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        rx_a  = 1'b1;
        @(negedge clk);
        check("t6_rst_outs", 32'({rx_data_a, rx_perr_a, rx_ferr_a, rx_brk_a,
                                  rx_valid_a, overrun_a, busy_a}), 32'd0);
        rst_n = 1'b1;
        q_a.delete();
        repeat (32) @(negedge clk);
        check("t6_no_stale", 32'(rx_valid_a), 32'd0);
        q_a.push_back(mk(1'b0, 1'b0, 1'b0, 8'h7E));
        send_a(8'h7E, 1'b1, -1);
        consume_a("t6_clean");
        check("t6_empty", 32'(rx_valid_a), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
